// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the uart_tx arbiter slice.
//   S_ARB / S_REQ / S_WAIT : arbiter FSM state encodings
//   UART_DATA_W            : byte width of the uart_tx byte_in port
package uart_pkg;
  localparam logic [1:0] S_ARB  = 2'b00;
  localparam logic [1:0] S_REQ  = 2'b01;
  localparam logic [1:0] S_WAIT = 2'b10;
  localparam int UART_DATA_W = 8;
endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at or after ptr.
//   req : request vector
//   ptr : search start index (wraps N_REQ-1 -> 0)
//   gnt : one-hot grant (zero when nothing requests)
//   idx : index of the granted request
//   any : at least one request present
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] idx,
  output logic                     any
);
  localparam int IW = $clog2(N_REQ);
  logic [IW-1:0] j;
  // Scan from the farthest offset back to ptr so the nearest request wins last.
  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(ptr) + k) % N_REQ);
      if (req[j]) begin
        idx = j;
        any = 1'b1;
      end
    end
    gnt[idx] = any;
  end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one uart_tx among N_REQ byte sources, packet-locked round robin.
//   clk, rst_n          : clock, asynchronous active-low reset
//   cli_valid/data/last : per-source byte offer (data of source i at [i*DATA_W +: DATA_W])
//   cli_ready           : one-cycle accept pulse, at most one bit set
//   tx_req, tx_byte     : request and latched byte towards uart_tx
//   tx_busy             : uart_tx busy
//   gnt_id, locked      : current/last granted source, packet in progress
//   err_to              : one-cycle pulse when uart_tx never acknowledged a request
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = UART_DATA_W,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           cli_valid,
  input  logic [N_REQ*DATA_W-1:0]    cli_data,
  input  logic [N_REQ-1:0]           cli_last,
  output logic [N_REQ-1:0]           cli_ready,
  output logic                       tx_req,
  output logic [DATA_W-1:0]          tx_byte,
  input  logic                       tx_busy,
  output logic [$clog2(N_REQ)-1:0]   gnt_id,
  output logic                       locked,
  output logic                       err_to
);
  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(TIMEOUT);
  logic [1:0]        state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d, gnt_id_q, gnt_id_d, sel_idx, nxt_ptr;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
  logic              last_q, last_d, locked_q, locked_d, err_to_q, err_to_d;
  logic              sel_any, take;
  logic [N_REQ-1:0]  req_v, sel_gnt;
  logic [DATA_W-1:0] data_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_data
    assign data_a[i] = cli_data[i*DATA_W +: DATA_W];
  end

  // While a packet is open only the owner may be granted.
  assign req_v = locked_q ? cli_valid & (N_REQ'(1) << gnt_id_q) : cli_valid;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .req(req_v),
    .ptr(ptr_q),
    .gnt(sel_gnt),
    .idx(sel_idx),
    .any(sel_any)
  );

  assign take      = state_q == S_ARB && !tx_busy && sel_any;
  // Gated by rst_n so no accept can leak out while reset is held.
  assign cli_ready = take && rst_n ? sel_gnt : '0;
  assign nxt_ptr   = gnt_id_q == IW'(N_REQ - 1) ? '0 : gnt_id_q + 1'b1;
  assign tx_req    = state_q == S_REQ;
  assign tx_byte   = tx_byte_q;
  assign gnt_id    = gnt_id_q;
  assign locked    = locked_q;
  assign err_to    = err_to_q;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    tx_byte_d = tx_byte_q;
    last_d    = last_q;
    gnt_id_d  = gnt_id_q;
    locked_d  = locked_q;
    err_to_d  = 1'b0;
    case (state_q)
      S_ARB: if (take) begin
        tx_byte_d = data_a[sel_idx];
        last_d    = cli_last[sel_idx];
        gnt_id_d  = sel_idx;
        locked_d  = 1'b1;
        cnt_d     = '0;
        state_d   = S_REQ;
      end
      S_REQ: if (tx_busy) begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        // uart_tx never answered: drop the byte and release the source.
        err_to_d = 1'b1;
        locked_d = 1'b0;
        ptr_d    = nxt_ptr;
        cnt_d    = '0;
        state_d  = S_ARB;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_WAIT: if (!tx_busy) begin
        state_d  = S_ARB;
        locked_d = last_q ? 1'b0 : locked_q;
        ptr_d    = last_q ? nxt_ptr : ptr_q;
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_ARB;
      ptr_q     <= '0;
      cnt_q     <= '0;
      tx_byte_q <= '0;
      last_q    <= 1'b0;
      gnt_id_q  <= '0;
      locked_q  <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      tx_byte_q <= tx_byte_d;
      last_q    <= last_d;
      gnt_id_q  <= gnt_id_d;
      locked_q  <= locked_d;
      err_to_q  <= err_to_d;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: self-checking bench with source queues, a uart_tx model and a packet-order model.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  cli_valid = '0, cli_last = '0, cli_ready;
  logic [31:0] cli_data = '0;
  logic        tx_req, tx_busy = 1'b0, locked, err_to;
  logic [7:0]  tx_byte;
  logic [1:0]  gnt_id;

  int checks = 0, failures = 0;
  logic [7:0] sd [4][256];
  logic       sl [4][256];
  int         hd [4], tl [4], gap [4];
  logic [7:0] exp_q [$], rx_q [$];
  int         mptr = 0, bcnt = 0, pop_i = 0, n = 0, hi = 0;
  bit         busy = 0, ignore = 0, to_mode = 0, pop_v = 0;
  logic [7:0] acc_byte = '0;
  logic [1:0] acc_src = '0;

  uart_tx_arbiter dut (
    .clk(clk), .rst_n(rst_n), .cli_valid(cli_valid), .cli_data(cli_data),
    .cli_last(cli_last), .cli_ready(cli_ready), .tx_req(tx_req), .tx_byte(tx_byte),
    .tx_busy(tx_busy), .gnt_id(gnt_id), .locked(locked), .err_to(err_to)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input logic [7:0] d, input logic l);
    sd[s][tl[s]] = d;
    sl[s][tl[s]] = l;
    tl[s]++;
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      cli_valid[i] = hd[i] < tl[i] && gap[i] == 0;
      cli_data[i*8 +: 8] = cli_valid[i] ? sd[i][hd[i]] : 8'h00;
      cli_last[i] = cli_valid[i] && sl[i][hd[i]];
    end
    tx_busy = busy;
  endtask

  function automatic bit idle();
    idle = !pop_v;
    for (int i = 0; i < 4; i++) if (hd[i] < tl[i]) idle = 0;
  endfunction

  // Whole packets in strict round robin from the model pointer; pointer moves past each finished packet.
  function automatic void build_exp();
    int h [4];
    int f;
    bit l;
    for (int i = 0; i < 4; i++) h[i] = hd[i];
    exp_q.delete();
    do begin
      f = -1;
      for (int k = 0; k < 4; k++)
        if (f < 0 && h[(mptr + k) % 4] < tl[(mptr + k) % 4]) f = (mptr + k) % 4;
      if (f >= 0) begin
        do begin
          exp_q.push_back(sd[f][h[f]]);
          l = sl[f][h[f]];
          h[f]++;
        end while (!l && h[f] < tl[f]);
        mptr = (f + 1) % 4;
      end
    end while (f >= 0);
  endfunction

  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < 4; i++) if (gap[i] > 0) gap[i]--;
    if (pop_v) begin
      gap[pop_i] = sl[pop_i][hd[pop_i]] ? 0 : int'($urandom_range(0, 3));
      hd[pop_i]++;
      pop_v = 0;
    end
    if (busy) begin
      bcnt--;
      busy = bcnt > 0;
    end else if (tx_req && !ignore) begin
      chk("tx_byte", tx_byte, acc_byte);
      chk("gnt_id", gnt_id, acc_src);
      chk("locked_in_frame", locked, 1);
      rx_q.push_back(tx_byte);
      busy = 1;
      bcnt = $urandom_range(2, 5);
    end
    drive();
    #1;
    chk("ready_onehot0", $onehot0(cli_ready), 1);
    if (!to_mode) chk("err_to_idle", err_to, 0);
    if (busy) chk("ready_while_busy", cli_ready, 0);
    for (int i = 0; i < 4; i++) if (cli_ready[i]) begin
      chk("ready_valid", cli_valid[i], 1);
      pop_v = 1;
      pop_i = i;
      acc_byte = sd[i][hd[i]];
      acc_src = 2'(i);
    end
  endtask

  task automatic run_scn(input string tag, input int budget);
    int c = 0;
    bit done = 0;
    build_exp();
    rx_q.delete();
    while (!done && c < budget) begin
      cycle();
      c++;
      done = rx_q.size() >= exp_q.size() && !busy && idle();
    end
    chk({tag, "_done"}, c < budget, 1);
    repeat (4) cycle();
    chk({tag, "_count"}, rx_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++)
      chk({tag, "_byte"}, k < rx_q.size() ? {24'h0, rx_q[k]} : 32'hdead, exp_q[k]);
    chk({tag, "_unlocked"}, locked, 0);
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      gap[i] = 0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_tx_req"}, tx_req, 0);
    chk({tag, "_tx_byte"}, tx_byte, 0);
    chk({tag, "_gnt_id"}, gnt_id, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_err_to"}, err_to, 0);
    chk({tag, "_ready"}, cli_ready, 0);
  endtask

  initial begin
    busy = 1;
    bcnt = 10;
    push(0, 8'hA5, 1);
    drive();
    #1;
    chk_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    repeat (9) begin
      cycle();
      chk("busy_hold_ready", cli_ready, 0);
      chk("busy_hold_req", tx_req, 0);
    end
    run_scn("single", 200);

    push(0, 8'h11, 1);
    push(2, 8'h22, 1);
    run_scn("two_src", 300);

    for (int s = 0; s < 4; s++) push(s, 8'h80 + 8'(s), 1);
    run_scn("all_src", 400);

    push(1, 8'h10, 0);
    push(1, 8'h11, 0);
    push(1, 8'h12, 1);
    push(3, 8'h30, 1);
    push(3, 8'h31, 1);
    run_scn("lock", 600);

    ignore = 1;
    to_mode = 1;
    push(1, 8'h3C, 1);
    n = 0;
    while (!tx_req && n < 50) begin
      cycle();
      n++;
    end
    chk("to_start", n < 50, 1);
    hi = 0;
    while (tx_req && hi < 200) begin
      cycle();
      hi++;
    end
    chk("to_req_cycles", hi, 64);
    chk("to_pulse", err_to, 1);
    chk("to_req_low", tx_req, 0);
    chk("to_unlocked", locked, 0);
    cycle();
    chk("to_pulse_end", err_to, 0);
    to_mode = 0;
    ignore = 0;
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
    end
    mptr = 2;
    push(0, 8'h70, 1);
    push(2, 8'h72, 1);
    push(3, 8'h73, 1);
    run_scn("after_to", 400);

    push(2, 8'h41, 0);
    push(2, 8'h42, 0);
    push(2, 8'h43, 1);
    push(0, 8'h50, 1);
    rx_q.delete();
    n = 0;
    while (rx_q.size() < 1 && n < 200) begin
      cycle();
      n++;
    end
    chk("rst_reach", n < 200, 1);
    cycle();
    rst_n = 0;
    busy = 0;
    drive();
    #1;
    chk_zero("mid_rst");
    for (int i = 0; i < 4; i++) begin
      hd[i] = 0;
      tl[i] = 0;
      gap[i] = 0;
    end
    pop_v = 0;
    bcnt = 0;
    mptr = 0;
    drive();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    for (int s = 0; s < 4; s++) push(s, 8'h60 + 8'(s), 1);
    run_scn("post_rst", 400);

    repeat (8) begin
      for (int s = 0; s < 4; s++)
        if ($urandom_range(0, 2) != 0)
          for (int p = 0; p < int'($urandom_range(1, 2)); p++) begin
            int len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) push(s, 8'($urandom), b == len - 1);
          end
      run_scn("rand", 3000);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
